mem_port_arbiter: RTL and testbench

Shares the core's single unified memory port between the instruction-fetch requester and the MEM-stage data requester. The MEM-stage data requester is driven from the `interconnection_struct` fields `mem_rd`, `mem_wr`, `mem_wr_en`, `mem_addr` and `mem_data`. The block arbitrates, registers the winning request toward memory, tracks the single outstanding transaction and routes the response back to its owner. It sits between the IF/MEM stages and the memory interface.

---
 rtl/mem_port_arbiter_pkg.sv | 23 ++
 rtl/mem_arb_prio.sv | 59 +++++
 rtl/mem_port_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
//   Shared types for the unified memory port arbiter:
//     mem_arb_state_t : transaction FSM encoding (IDLE / WAIT_GNT / WAIT_RESP)
//     mem_port_req_t  : registered request presented on the memory port
package mem_port_arbiter_pkg;

  localparam int unsigned MEM_ADDR_W = 64;
  localparam int unsigned MEM_DATA_W = 64;

  typedef enum logic [1:0] {
    ARB_IDLE      = 2'd0,
    ARB_WAIT_GNT  = 2'd1,
    ARB_WAIT_RESP = 2'd2
  } mem_arb_state_t;

  typedef struct packed {
    logic                  we;
    logic [7:0]            be;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] wdata;
  } mem_port_req_t;

endpackage

// File: rtl/mem_arb_prio.sv
// mem_arb_prio
//   Winner select for the memory port. Data requests win over fetch.
//   With MEM_ARB_FAIR_EN defined, a saturating counter of data wins taken
//   while fetch was waiting hands one window to fetch after STARVE_MAX of them.
// Ports:
//   clk, rst          : clock, synchronous active-high reset (counter only)
//   window            : acceptance window is open this cycle
//   if_req, dm_req    : fetch / data requests
//   grant_if, grant_dm: one-hot winner, only asserted inside the window
module mem_arb_prio
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic window,
  input  logic if_req,
  input  logic dm_req,
  output logic grant_if,
  output logic grant_dm
);

`ifdef MEM_ARB_FAIR_EN
  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] starve_cnt;
  logic             fetch_turn;

  assign fetch_turn = (starve_cnt == CNT_W'(STARVE_MAX));

  always_comb begin
    grant_dm = window & dm_req & ~(if_req & fetch_turn);
    grant_if = window & if_req & ~grant_dm;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (window) begin
      if (!if_req || grant_if) begin
        starve_cnt <= '0;
      end else if (grant_dm && !fetch_turn) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end
`else
  always_comb begin
    grant_dm = window & dm_req;
    grant_if = window & if_req & ~dm_req;
  end

  logic unused_fair;
  assign unused_fair = ^{clk, rst};
  localparam int unsigned unused_starve_max = STARVE_MAX;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one memory port between instruction fetch (if_*) and the MEM-stage
//   data requester (dm_*). One transaction outstanding at a time; the winning
//   request is registered onto mem_*, and the response is routed to its owner.
//   Optional fairness: define MEM_ARB_FAIR_EN (see mem_arb_prio).
// Ports:
//   clk, rst                         : clock, synchronous active-high reset
//   if_req/if_addr/if_flush          : fetch request, flush of in-flight fetch
//   if_gnt/if_rvalid/if_rdata        : fetch accept and response
//   dm_req/dm_we/dm_be/dm_addr/dm_wdata : data request
//   dm_gnt/dm_rvalid/dm_rdata        : data accept and response (writes ack too)
//   mem_req/mem_we/mem_be/mem_addr/mem_wdata : registered memory request
//   mem_gnt/mem_rvalid/mem_rdata     : memory accept and response
//   busy                             : a transaction is held
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = 64,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [7:0]        dm_be,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [7:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  mem_arb_state_t state_q;
  mem_port_req_t  req_q;
  mem_port_req_t  next_req;
  logic           mem_req_q;
  logic           owner_if_q;
  logic           kill_q;
  logic           window;
  logic           resp;
  logic           grant_if;
  logic           grant_dm;

  // Reset gates the window and response so every output reads 0 during rst.
  assign resp   = ~rst & (state_q == ARB_WAIT_RESP) & mem_rvalid;
  assign window = ~rst & ((state_q == ARB_IDLE) | resp);

  mem_arb_prio #(
    .STARVE_MAX (STARVE_MAX)
  ) u_prio (
    .clk      (clk),
    .rst      (rst),
    .window   (window),
    .if_req   (if_req),
    .dm_req   (dm_req),
    .grant_if (grant_if),
    .grant_dm (grant_dm)
  );

  assign if_gnt    = grant_if;
  assign dm_gnt    = grant_dm;
  assign if_rvalid = resp & owner_if_q & ~kill_q;
  assign dm_rvalid = resp & ~owner_if_q;
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign dm_rdata  = dm_rvalid ? mem_rdata : '0;

  assign mem_req   = mem_req_q;
  assign mem_we    = req_q.we;
  assign mem_be    = req_q.be;
  assign mem_addr  = req_q.addr[ADDR_W-1:0];
  assign mem_wdata = req_q.wdata[DATA_W-1:0];
  assign busy      = (state_q != ARB_IDLE);

  always_comb begin
    next_req = req_q;
    if (grant_dm) begin
      next_req.we    = dm_we;
      next_req.be    = dm_be;
      next_req.addr  = MEM_ADDR_W'(dm_addr);
      next_req.wdata = MEM_DATA_W'(dm_wdata);
    end else if (grant_if) begin
      next_req.we    = 1'b0;
      next_req.be    = '1;
      next_req.addr  = MEM_ADDR_W'(if_addr);
      next_req.wdata = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      req_q      <= '0;
      mem_req_q  <= 1'b0;
      owner_if_q <= 1'b0;
      kill_q     <= 1'b0;
    end else begin
      unique case (state_q)
        ARB_IDLE, ARB_WAIT_RESP: begin
          if (window) begin
            // A new acceptance overlapping the response starts the next
            // transaction directly, with its own kill state.
            if (grant_if || grant_dm) begin
              state_q    <= ARB_WAIT_GNT;
              req_q      <= next_req;
              mem_req_q  <= 1'b1;
              owner_if_q <= grant_if;
              kill_q     <= grant_if & if_flush;
            end else begin
              state_q <= ARB_IDLE;
              kill_q  <= 1'b0;
            end
          end else begin
            kill_q <= kill_q | (owner_if_q & if_flush);
          end
        end
        ARB_WAIT_GNT: begin
          kill_q <= kill_q | (owner_if_q & if_flush);
          if (mem_gnt) begin
            state_q   <= ARB_WAIT_RESP;
            mem_req_q <= 1'b0;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [63:0] if_addr;
  logic        if_flush;
  logic        if_gnt;
  logic        if_rvalid;
  logic [63:0] if_rdata;
  logic        dm_req;
  logic        dm_we;
  logic [7:0]  dm_be;
  logic [63:0] dm_addr;
  logic [63:0] dm_wdata;
  logic        dm_gnt;
  logic        dm_rvalid;
  logic [63:0] dm_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [7:0]  mem_be;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;
  logic        busy;

  mem_port_arbiter #(
    .ADDR_W     (64),
    .DATA_W     (64),
    .STARVE_MAX (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_flush   (if_flush),
    .if_gnt     (if_gnt),
    .if_rvalid  (if_rvalid),
    .if_rdata   (if_rdata),
    .dm_req     (dm_req),
    .dm_we      (dm_we),
    .dm_be      (dm_be),
    .dm_addr    (dm_addr),
    .dm_wdata   (dm_wdata),
    .dm_gnt     (dm_gnt),
    .dm_rvalid  (dm_rvalid),
    .dm_rdata   (dm_rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad   = 0;

  typedef struct packed {
    logic        is_if;
    logic [63:0] data;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic is_if, input logic [63:0] data);
    exp_t e;
    e.is_if = is_if;
    e.data  = data;
    sb.push_back(e);
  endtask

  // Response monitor: every rvalid must match the head of the scoreboard.
  always @(negedge clk) begin
    if (if_rvalid || dm_rvalid) begin
      exp_t e;
      if (if_rvalid && dm_rvalid) begin
        chk("rvalid_onehot", {if_rvalid, dm_rvalid}, 64'h1);
      end else if (sb.size() == 0) begin
        chk("unexpected_rvalid", {if_rvalid, dm_rvalid}, 64'h0);
      end else begin
        e = sb.pop_front();
        chk("resp_owner_if", {63'h0, if_rvalid}, {63'h0, e.is_if});
        if (e.is_if) begin
          chk("if_rdata", if_rdata, e.data);
          chk("dm_rdata_idle", dm_rdata, 64'h0);
        end else begin
          chk("dm_rdata", dm_rdata, e.data);
          chk("if_rdata_idle", if_rdata, 64'h0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic fetch_only(input logic [63:0] addr, input logic [63:0] data);
    if_req = 1'b1; if_addr = addr;
    @(negedge clk);
    chk("fo_if_gnt", {63'h0, if_gnt}, 64'h1);
    chk("fo_dm_gnt", {63'h0, dm_gnt}, 64'h0);
    nxt();
    if_req = 1'b0; mem_gnt = 1'b1;
    @(negedge clk);
    chk("fo_mem_req", {63'h0, mem_req}, 64'h1);
    chk("fo_mem_addr", mem_addr, addr);
    chk("fo_mem_we", {63'h0, mem_we}, 64'h0);
    chk("fo_busy", {63'h0, busy}, 64'h1);
    nxt();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = data;
    push(1'b1, data);
    @(negedge clk);
    chk("fo_if_rvalid", {63'h0, if_rvalid}, 64'h1);
    nxt();
    mem_rvalid = 1'b0; mem_rdata = '0;
    @(negedge clk);
    chk("fo_idle", {63'h0, busy}, 64'h0);
    nxt();
  endtask

  initial begin
    logic exp_f[10];
    rst = 1'b1; if_req = 0; if_addr = '0; if_flush = 0;
    dm_req = 0; dm_we = 0; dm_be = '0; dm_addr = '0; dm_wdata = '0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
    nxt(); nxt();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", {63'h0, busy}, 64'h0);
    chk("rst_mem_req", {63'h0, mem_req}, 64'h0);
    chk("rst_mem_addr", mem_addr, 64'h0);
    nxt();

    // Fetch only
    fetch_only(64'h1000, 64'hDEAD);

    // Simultaneous: data write wins, fetch granted in the write's rvalid cycle
    dm_req = 1; dm_we = 1; dm_be = 8'h0F; dm_addr = 64'h2000; dm_wdata = 64'h55;
    if_req = 1; if_addr = 64'h1008;
    @(negedge clk);
    chk("sim_dm_gnt", {63'h0, dm_gnt}, 64'h1);
    chk("sim_if_gnt0", {63'h0, if_gnt}, 64'h0);
    nxt();
    dm_req = 0; dm_we = 0; mem_gnt = 1;
    @(negedge clk);
    chk("sim_mem_we", {63'h0, mem_we}, 64'h1);
    chk("sim_mem_be", {56'h0, mem_be}, 64'h0F);
    chk("sim_mem_addr", mem_addr, 64'h2000);
    chk("sim_mem_wdata", mem_wdata, 64'h55);
    chk("sim_if_gnt_wait", {63'h0, if_gnt}, 64'h0);
    nxt();
    mem_gnt = 0; mem_rvalid = 1; mem_rdata = 64'h0;
    push(1'b0, 64'h0);
    @(negedge clk);
    chk("sim_if_gnt_rv", {63'h0, if_gnt}, 64'h1);
    nxt();
    if_req = 0; mem_rvalid = 0; mem_gnt = 1;
    @(negedge clk);
    chk("sim_f_mem_addr", mem_addr, 64'h1008);
    chk("sim_f_mem_we", {63'h0, mem_we}, 64'h0);
    chk("sim_f_mem_be", {56'h0, mem_be}, 64'hFF);
    nxt();
    mem_gnt = 0; mem_rvalid = 1; mem_rdata = 64'hBEEF;
    push(1'b1, 64'hBEEF);
    nxt();
    mem_rvalid = 0;
    nxt();

    // Backpressure: data read, mem_gnt low 5 cycles, fetch waiting
    dm_req = 1; dm_we = 0; dm_be = 8'hFF; dm_addr = 64'h3000; dm_wdata = 64'h0;
    @(negedge clk);
    chk("bp_dm_gnt", {63'h0, dm_gnt}, 64'h1);
    nxt();
    dm_req = 0; if_req = 1; if_addr = 64'h1010;
    for (int i = 0; i < 6; i++) begin
      mem_gnt = (i == 5);
      @(negedge clk);
      chk("bp_mem_req", {63'h0, mem_req}, 64'h1);
      chk("bp_mem_addr", mem_addr, 64'h3000);
      chk("bp_mem_be", {56'h0, mem_be}, 64'hFF);
      chk("bp_if_gnt", {63'h0, if_gnt}, 64'h0);
      nxt();
    end
    mem_gnt = 0; mem_rvalid = 1; mem_rdata = 64'h1234;
    push(1'b0, 64'h1234);
    @(negedge clk);
    chk("bp_if_gnt_rv", {63'h0, if_gnt}, 64'h1);
    nxt();
    // Flush the fetch while it waits for its response
    if_req = 0; mem_rvalid = 0; mem_gnt = 1;
    nxt();
    mem_gnt = 0; if_flush = 1;
    nxt();
    if_flush = 0; mem_rvalid = 1; mem_rdata = 64'hBAD;
    @(negedge clk);
    chk("fl_if_rvalid", {63'h0, if_rvalid}, 64'h0);
    chk("fl_if_rdata", if_rdata, 64'h0);
    nxt();
    mem_rvalid = 0;
    fetch_only(64'h1018, 64'hCAFE);

    // Flush in the same cycle as the grant kills the new fetch
    if_req = 1; if_flush = 1; if_addr = 64'h1020;
    @(negedge clk);
    chk("flg_if_gnt", {63'h0, if_gnt}, 64'h1);
    nxt();
    if_req = 0; if_flush = 0; mem_gnt = 1;
    nxt();
    mem_gnt = 0; mem_rvalid = 1; mem_rdata = 64'h99;
    @(negedge clk);
    chk("flg_if_rvalid", {63'h0, if_rvalid}, 64'h0);
    nxt();
    mem_rvalid = 0;
    nxt();

    // Continuous contention: grant pattern
    for (int k = 0; k < 10; k++) begin
`ifdef MEM_ARB_FAIR_EN
      exp_f[k] = ((k % 5) == 4);
`else
      exp_f[k] = 1'b0;
`endif
    end
    if_req = 1; if_addr = 64'h5000;
    dm_req = 1; dm_we = 0; dm_be = 8'hFF; dm_addr = 64'h4000;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) begin
        mem_rvalid = 1; mem_rdata = 64'h100 + 64'(k - 1);
        push(exp_f[k-1], 64'h100 + 64'(k - 1));
      end
      @(negedge clk);
      chk("pat_if_gnt", {63'h0, if_gnt}, {63'h0, exp_f[k]});
      chk("pat_dm_gnt", {63'h0, dm_gnt}, {63'h0, ~exp_f[k]});
      nxt();
      mem_rvalid = 0; mem_gnt = 1;
      @(negedge clk);
      chk("pat_mem_addr", mem_addr, exp_f[k] ? 64'h5000 : 64'h4000);
      nxt();
      mem_gnt = 0;
    end
    if_req = 0; dm_req = 0;
    mem_rvalid = 1; mem_rdata = 64'h109;
    push(exp_f[9], 64'h109);
    nxt();
    mem_rvalid = 0;
    nxt();

    // Reset in WAIT_RESP, then a late response
    dm_req = 1; dm_we = 1; dm_be = 8'h3C; dm_addr = 64'h6000; dm_wdata = 64'hA5;
    nxt();
    dm_req = 0; mem_gnt = 1;
    nxt();
    mem_gnt = 0; rst = 1;
    nxt();
    rst = 0;
    @(negedge clk);
    chk("rm_busy", {63'h0, busy}, 64'h0);
    chk("rm_mem_req", {63'h0, mem_req}, 64'h0);
    chk("rm_mem_we", {63'h0, mem_we}, 64'h0);
    chk("rm_mem_be", {56'h0, mem_be}, 64'h0);
    chk("rm_mem_addr", mem_addr, 64'h0);
    chk("rm_mem_wdata", mem_wdata, 64'h0);
    nxt();
    mem_rvalid = 1; mem_rdata = 64'h77;
    @(negedge clk);
    chk("rm_late_dm_rvalid", {63'h0, dm_rvalid}, 64'h0);
    chk("rm_late_if_rvalid", {63'h0, if_rvalid}, 64'h0);
    chk("rm_late_dm_rdata", dm_rdata, 64'h0);
    nxt();
    mem_rvalid = 0;
    nxt();

    chk("sb_drained", 64'(sb.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
